// File: rtl/led_result_buffer_pkg.sv
// Shared types and widths for the LED result buffer.
package led_result_buffer_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned TAG_W  = 8;
    localparam int unsigned DROP_W = 8;

    typedef enum logic {
        StIdle,
        StShow
    } disp_state_t;

endpackage

// File: rtl/led_result_buffer_if.sv
// Result input strobe plus display/status outputs of the LED result buffer.
interface led_result_buffer_if
    import led_result_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 8
);

    logic                       res_valid;
    logic [DATA_W-1:0]          res_data;
    logic [TAG_W-1:0]           res_tag;
    logic [TAG_W+DATA_W-1:0]    led;
    logic                       full;
    logic [$clog2(DEPTH+1)-1:0] level;
    logic [DROP_W-1:0]          drop_cnt;
    logic                       busy;

    // Core side: produces results, observes display status.
    modport master (
        output res_valid, res_data, res_tag,
        input  led, full, level, drop_cnt, busy
    );

    // Buffer side.
    modport slave (
        input  res_valid, res_data, res_tag,
        output led, full, level, drop_cnt, busy
    );

endinterface

// File: rtl/led_result_buffer_sync_fifo.sv
// Registered FIFO with separate occupancy count; pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = $clog2(DEPTH + 1);
    localparam logic [LvlW-1:0] DepthLvl = LvlW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [LvlW-1:0]  level_q;

    // Storage array; contents need no reset since pointers/level define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop) begin
                level_q <= level_q + 1'b1;
            end else if (pop && !push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

    assign dout  = mem[rd_ptr_q];
    assign level = level_q;
    assign full  = (level_q == DepthLvl);
    assign empty = (level_q == '0);

endmodule

// File: rtl/led_result_buffer.sv
// Buffers core results and shows each on the LEDs for a fixed dwell time.
module led_result_buffer
    import led_result_buffer_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    led_result_buffer_if.slave  bus
);

    localparam int unsigned EntW  = TAG_W + DATA_W;
    localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HoldW-1:0] HoldReload = HoldW'(HOLD_CYCLES - 1);

    disp_state_t       state_q, state_d;
    logic [HoldW-1:0]  hold_q, hold_d;
    logic [EntW-1:0]   led_q;
    logic [DROP_W-1:0] drop_q;

    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [EntW-1:0]   head;
    logic [$clog2(DEPTH+1)-1:0] level;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EntW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({bus.res_tag, bus.res_data}),
        .dout  (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    // A full FIFO still accepts a push when the display pops in the same cycle.
    assign push = bus.res_valid && (!full || pop);

    // Display FSM: next state, dwell counter and pop decision.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    hold_d  = HoldReload;
                    state_d = StShow;
                end
            end
            StShow: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - 1'b1;
                end else if (!empty) begin
                    pop    = 1'b1;
                    hold_d = HoldReload;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, dwell counter, displayed entry and saturating drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            hold_q  <= '0;
            led_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            if (pop) begin
                led_q <= head;
            end
            if (bus.res_valid && !push && (drop_q != '1)) begin
                drop_q <= drop_q + 1'b1;
            end
        end
    end

    assign bus.led      = led_q;
    assign bus.full     = full;
    assign bus.level    = level;
    assign bus.drop_cnt = drop_q;
    assign bus.busy     = (state_q == StShow);

endmodule

// File: tb/tb_led_result_buffer.sv
// Scoreboard bench: stimulus queues expected LED words, a monitor checks each display.
module tb_led_result_buffer;
    import led_result_buffer_pkg::*;

    localparam int unsigned HOLD = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    led_result_buffer_if #(.DEPTH(8)) bus ();
    led_result_buffer_if #(.DEPTH(8)) bus_sat ();

    led_result_buffer #(.DEPTH(8), .HOLD_CYCLES(HOLD)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Long dwell so nothing drains during the saturation test.
    led_result_buffer #(.DEPTH(8), .HOLD_CYCLES(1000)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_sat)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a new entry starts when busy rises or a full dwell elapses while busy.
    bit prev_busy = 1'b0;
    int dwell = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_busy = 1'b0;
            dwell     = 0;
        end else begin
            if (bus.busy && (!prev_busy || dwell == HOLD)) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_display: got led 0x%0h, expected none", bus.led);
                end else begin
                    check("display_order", bus.led, exp_q.pop_front());
                end
                dwell = 1;
            end else if (bus.busy) begin
                dwell++;
            end else if (prev_busy) begin
                check("dwell_len", dwell, HOLD);
                check("no_gap", exp_q.size(), 0);
                dwell = 0;
            end
            prev_busy = bus.busy;
        end
    end

    task automatic drive(input bit v, input logic [7:0] tag, input logic [7:0] data);
        @(negedge clk);
        bus.res_valid = v;
        bus.res_tag   = tag;
        bus.res_data  = data;
    endtask

    task automatic push_exp(input logic [7:0] tag, input logic [7:0] data);
        drive(1'b1, tag, data);
        exp_q.push_back({tag, data});
    endtask

    task automatic drain(input string name);
        bit done = 1'b0;
        @(negedge clk);
        bus.res_valid = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.busy) begin
                done = 1'b1;
                break;
            end
        end
        check(name, done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.res_valid = 1'b0;     bus.res_tag = '0;     bus.res_data = '0;
        bus_sat.res_valid = 1'b0; bus_sat.res_tag = '0; bus_sat.res_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_led", bus.led, 0);
        check("rst_full", bus.full, 0);
        check("rst_level", bus.level, 0);
        check("rst_drop", bus.drop_cnt, 0);
        check("rst_busy", bus.busy, 0);

        // 1: single push, registered path: led changes one edge after the push edge
        push_exp(8'h03, 8'hA5);
        drive(1'b0, 8'h00, 8'h00);
        check("t1_level_after_push", bus.level, 1);
        check("t1_led_not_bypassed", bus.led, 0);
        check("t1_busy_not_yet", bus.busy, 0);
        drive(1'b0, 8'h00, 8'h00);
        check("t1_led", bus.led, 16'h03A5);
        check("t1_busy", bus.busy, 1);
        check("t1_level_popped", bus.level, 0);
        drain("t1_drain");
        check("t1_led_kept", bus.led, 16'h03A5);
        check("t1_idle", bus.busy, 0);

        // 2: three back-to-back results shown in order with no gap
        push_exp(8'h20, 8'h01);
        push_exp(8'h21, 8'h02);
        push_exp(8'h22, 8'h03);
        drain("t2_drain");

        // 3: pops land on edges 2, 6 and 10, so 11 pushes fit and the 12th is rejected
        for (int k = 1; k <= 11; k++) begin
            push_exp(8'(8'h30 + k), 8'(8'hC0 + k));
        end
        drive(1'b1, 8'h3C, 8'hCC);
        drive(1'b0, 8'h00, 8'h00);
        check("t3_level", bus.level, 8);
        check("t3_full", bus.full, 1);
        check("t3_drop", bus.drop_cnt, 1);
        // 4: dwell expires on edge 14; a push on that edge is accepted while full
        push_exp(8'h3D, 8'hCD);
        drive(1'b0, 8'h00, 8'h00);
        check("t4_level", bus.level, 8);
        check("t4_full", bus.full, 1);
        check("t4_drop", bus.drop_cnt, 1);
        drain("t3_drain");

        // 5: asynchronous reset mid-dwell with five entries queued
        for (int k = 1; k <= 7; k++) begin
            push_exp(8'(8'h50 + k), 8'(8'h70 + k));
        end
        @(negedge clk);
        bus.res_valid = 1'b0;
        check("t5_level_pre", bus.level, 5);
        check("t5_busy_pre", bus.busy, 1);
        #2 rst = 1'b1;
        #1;
        check("t5_led", bus.led, 0);
        check("t5_level", bus.level, 0);
        check("t5_busy", bus.busy, 0);
        check("t5_drop", bus.drop_cnt, 0);
        check("t5_full", bus.full, 0);
        exp_q.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        push_exp(8'h5A, 8'h5B);
        drain("t5_drain");
        check("t5_led_after", bus.led, 16'h5A5B);

        // 6: 300 pushes, 9 accepted (one popped at once), drops saturate at 255
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i == 100) check("t6_drop_100", bus_sat.drop_cnt, 91);
            if (i == 264) check("t6_drop_264", bus_sat.drop_cnt, 255);
            bus_sat.res_valid = 1'b1;
            bus_sat.res_tag   = i[7:0];
            bus_sat.res_data  = 8'(i + 1);
        end
        @(negedge clk);
        bus_sat.res_valid = 1'b0;
        check("t6_drop_sat", bus_sat.drop_cnt, 255);
        check("t6_full", bus_sat.full, 1);
        check("t6_level", bus_sat.level, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
